// File: rtl/ipsl_pcie_dma_cpld_sched_if.sv
// Request and read-command bus between RX, the completion scheduler and the CPLD read controller.
interface ipsl_pcie_dma_cpld_sched_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [63:0] i_req_addr;
    logic [9:0]  i_req_length;
    logic [7:0]  i_req_tag;
    logic [15:0] i_req_id;
    logic [2:0]  i_max_payload;
    logic        i_tx_hold;
    logic        i_last_data;
    logic        o_rd_en;
    logic [9:0]  o_rd_length;
    logic [63:0] o_rd_addr;
    logic [7:0]  o_cpl_tag;
    logic [15:0] o_cpl_req_id;
    logic [11:0] o_cpl_byte_cnt;
    logic [6:0]  o_cpl_lower_addr;
    logic        o_busy;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_length, i_req_tag, i_req_id,
               i_max_payload, i_tx_hold, i_last_data,
        output o_req_ready, o_rd_en, o_rd_length, o_rd_addr, o_cpl_tag,
               o_cpl_req_id, o_cpl_byte_cnt, o_cpl_lower_addr, o_busy
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_length, i_req_tag, i_req_id,
               i_max_payload, i_tx_hold, i_last_data,
        input  o_req_ready, o_rd_en, o_rd_length, o_rd_addr, o_cpl_tag,
               o_cpl_req_id, o_cpl_byte_cnt, o_cpl_lower_addr, o_busy
    );
endinterface

// File: rtl/ipsl_pcie_dma_cpld_sched.sv
// Completion scheduler: queues memory-read requests, splits them into MPS-sized segments and
// issues one read command per segment, waiting for last_data before issuing the next.
module ipsl_pcie_dma_cpld_sched #(
    parameter int REQ_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ipsl_pcie_dma_cpld_sched_if.slave      bus
);

    localparam int             PW       = $clog2(REQ_DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(REQ_DEPTH);

    typedef struct packed {
        logic [63:0] addr;
        logic [9:0]  length;
        logic [7:0]  tag;
        logic [15:0] id;
    } req_t;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

    state_t        state, state_nxt;
    req_t          mem [REQ_DEPTH];
    req_t          ent;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, issue_go, seg_end;
    logic [10:0]   remaining_dw, mps_dw, seg_dw, seg_nxt;
    logic [63:0]   cur_addr;
    logic [2:0]    mps_code;

    assign push                 = bus.i_req_valid && bus.o_req_ready;
    assign bus.o_req_ready      = (count != FULL_CNT);
    assign bus.o_busy           = (state != IDLE) || (count != '0);
    assign bus.o_cpl_lower_addr = {bus.o_rd_addr[6:2], 2'b00};
    assign mps_code             = (bus.i_max_payload > 3'd5) ? 3'd5 : bus.i_max_payload;
    assign seg_nxt              = (remaining_dw < mps_dw) ? remaining_dw : mps_dw;

    // Request FIFO bookkeeping; a pending push is refused when full even if a pop coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.i_req_addr, bus.i_req_length, bus.i_req_tag, bus.i_req_id};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = LOAD;
            LOAD:    state_nxt = ISSUE;
            ISSUE:   if (!bus.i_tx_hold) state_nxt = WAIT;
            WAIT:    if (bus.i_last_data) state_nxt = (remaining_dw == seg_dw) ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        issue_go = 1'b0;
        seg_end  = 1'b0;
        case (state)
            IDLE:    pop      = (count != '0);
            ISSUE:   issue_go = !bus.i_tx_hold;
            WAIT:    seg_end  = bus.i_last_data;
            default: ;
        endcase
    end

    // Segment datapath; re-initialised at LOAD, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (pop) ent <= mem[rd_ptr];
        if (state == LOAD) begin
            remaining_dw <= (ent.length == 10'd0) ? 11'd1024 : {1'b0, ent.length};
            mps_dw       <= 11'd32 << mps_code;
            cur_addr     <= ent.addr & ~64'h3;
        end
        if (issue_go) seg_dw <= seg_nxt;
        if (seg_end) begin
            remaining_dw <= remaining_dw - seg_dw;
            cur_addr     <= cur_addr + {51'd0, seg_dw, 2'b00};
        end
    end

    // Command and header fields change only on an issue, so they hold until the next o_rd_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_rd_en        <= 1'b0;
            bus.o_rd_length    <= '0;
            bus.o_rd_addr      <= '0;
            bus.o_cpl_tag      <= '0;
            bus.o_cpl_req_id   <= '0;
            bus.o_cpl_byte_cnt <= '0;
        end else begin
            bus.o_rd_en <= issue_go;
            if (issue_go) begin
                bus.o_rd_length    <= seg_nxt[9:0];
                bus.o_rd_addr      <= cur_addr;
                bus.o_cpl_tag      <= ent.tag;
                bus.o_cpl_req_id   <= ent.id;
                bus.o_cpl_byte_cnt <= {remaining_dw[9:0], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_ipsl_pcie_dma_cpld_sched.sv
// Scoreboard bench for the completion scheduler: expected segments are queued when a request is
// accepted and compared against every o_rd_en; a built-in responder returns last_data.
module tb_ipsl_pcie_dma_cpld_sched;

    typedef struct {
        logic [9:0]  len;
        logic [63:0] addr;
        logic [11:0] bc;
        logic [7:0]  tag;
        logic [15:0] id;
    } seg_t;

    logic clk;
    logic rst_n;
    ipsl_pcie_dma_cpld_sched_if bus();

    ipsl_pcie_dma_cpld_sched #(.REQ_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   seg_count = 0;
    int   tick_no = 0;
    int   last_ld_tick = -1;
    int   resp_cnt = 0;
    int   resp_delay = 1;
    bit   outstanding = 0;
    bit   pending = 0;
    bit   auto_resp = 1;
    bit   man_pulse = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference split of one request into segments.
    task automatic model_req(input logic [63:0] a, input logic [9:0] l, input logic [7:0] t,
                             input logic [15:0] i, input logic [2:0] code);
        int rem, mps, s;
        logic [63:0] ad;
        seg_t e;
        rem = (l == 10'd0) ? 1024 : int'(l);
        mps = 32 << ((code > 3'd5) ? 5 : int'(code));
        ad  = a & ~64'h3;
        while (rem > 0) begin
            s      = (rem < mps) ? rem : mps;
            e.len  = 10'(s);
            e.addr = ad;
            e.bc   = 12'((rem * 4) % 4096);
            e.tag  = t;
            e.id   = i;
            sb.push_back(e);
            rem -= s;
            ad  += 64'(s * 4);
        end
    endtask

    // One clock: sample at the falling edge, then drive last_data for the next rising edge.
    task automatic tick();
        seg_t e;
        @(negedge clk);
        tick_no++;
        if (rst_n && bus.o_rd_en) begin
            check("no_overlap", 64'(outstanding), 0);
            if (last_ld_tick >= 0) check("seg_gap", 64'(tick_no - last_ld_tick >= 2), 1);
            if (sb.size() == 0) begin
                check("rd_en_expected", 0, 1);
            end else begin
                e = sb.pop_front();
                check("rd_length", 64'(bus.o_rd_length), 64'(e.len));
                check("rd_addr", bus.o_rd_addr, e.addr);
                check("byte_cnt", 64'(bus.o_cpl_byte_cnt), 64'(e.bc));
                check("lower_addr", 64'(bus.o_cpl_lower_addr), e.addr & 64'h7c);
                check("cpl_tag", 64'(bus.o_cpl_tag), 64'(e.tag));
                check("cpl_req_id", 64'(bus.o_cpl_req_id), 64'(e.id));
            end
            outstanding = 1;
            pending     = 1;
            resp_cnt    = resp_delay;
            seg_count++;
        end
        bus.i_last_data = 1'b0;
        if (man_pulse) begin
            bus.i_last_data = 1'b1;
            man_pulse       = 0;
            last_ld_tick    = tick_no;
        end else if (auto_resp && pending) begin
            if (resp_cnt == 0) begin
                bus.i_last_data = 1'b1;
                pending         = 0;
                outstanding     = 0;
                last_ld_tick    = tick_no;
            end else begin
                resp_cnt--;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.o_req_ready && n < 300) begin
            tick();
            n++;
        end
        check("req_ready_in_time", 64'(bus.o_req_ready), 1);
    endtask

    task automatic set_req(input logic [63:0] a, input logic [9:0] l, input logic [7:0] t,
                           input logic [15:0] i);
        bus.i_req_addr   = a;
        bus.i_req_length = l;
        bus.i_req_tag    = t;
        bus.i_req_id     = i;
        bus.i_req_valid  = 1'b1;
    endtask

    task automatic finish_push();
        wait_ready();
        model_req(bus.i_req_addr, bus.i_req_length, bus.i_req_tag, bus.i_req_id, bus.i_max_payload);
        tick();
        bus.i_req_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] a, input logic [9:0] l, input logic [7:0] t,
                        input logic [15:0] i);
        set_req(a, l, t, i);
        finish_push();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.o_busy || pending || sb.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_in_time", 64'(n < 3000), 1);
        check("sb_empty", 64'(sb.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(bus.o_rd_en), 0);
        check({tag, "_ready"}, 64'(bus.o_req_ready), 1);
        check({tag, "_busy"}, 64'(bus.o_busy), 0);
        check({tag, "_rd_length"}, 64'(bus.o_rd_length), 0);
        check({tag, "_rd_addr"}, bus.o_rd_addr, 0);
        check({tag, "_byte_cnt"}, 64'(bus.o_cpl_byte_cnt), 0);
        check({tag, "_tag"}, 64'(bus.o_cpl_tag), 0);
        check({tag, "_req_id"}, 64'(bus.o_cpl_req_id), 0);
        check({tag, "_lower"}, 64'(bus.o_cpl_lower_addr), 0);
    endtask

    initial begin
        int base;
        int n;
        rst_n             = 1'b0;
        bus.i_req_valid   = 1'b0;
        bus.i_req_addr    = '0;
        bus.i_req_length  = '0;
        bus.i_req_tag     = '0;
        bus.i_req_id      = '0;
        bus.i_max_payload = 3'd0;
        bus.i_tx_hold     = 1'b0;
        bus.i_last_data   = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Single short request, with first-command latency
        send(64'h1000_0040, 10'd16, 8'h11, 16'hABCD);
        tick();
        check("lat_edge1", 64'(bus.o_rd_en), 0);
        tick();
        check("lat_edge2", 64'(bus.o_rd_en), 0);
        base = seg_count;
        tick();
        check("lat_edge3", 64'(seg_count - base), 1);
        wait_idle();
        check("t1_len", 64'(bus.o_rd_length), 16);
        check("t1_addr", bus.o_rd_addr, 64'h1000_0040);
        check("t1_bc", 64'(bus.o_cpl_byte_cnt), 64);
        check("t1_lower", 64'(bus.o_cpl_lower_addr), 64'h40);
        check("t1_busy", 64'(bus.o_busy), 0);

        // Three-segment split with a slower responder
        resp_delay = 3;
        base = seg_count;
        send(64'h2000_0000, 10'd80, 8'h22, 16'h0102);
        wait_idle();
        check("t2_segs", 64'(seg_count - base), 3);
        check("t2_last_addr", bus.o_rd_addr, 64'h2000_0100);
        check("t2_last_bc", 64'(bus.o_cpl_byte_cnt), 64);
        check("t2_last_len", 64'(bus.o_rd_length), 16);
        resp_delay = 1;

        // 1024-DW request at maximum payload, then with an out-of-range MPS code
        for (int k = 0; k < 2; k++) begin
            bus.i_max_payload = (k == 0) ? 3'd5 : 3'd7;
            base = seg_count;
            send(64'h4000_0000, 10'd0, 8'h33, 16'h1234);
            wait_idle();
            check("t3_segs", 64'(seg_count - base), 1);
            check("t3_len", 64'(bus.o_rd_length), 0);
            check("t3_bc", 64'(bus.o_cpl_byte_cnt), 0);
        end
        bus.i_max_payload = 3'd0;

        // Fill the FIFO behind a held request; a sixth request waits for space
        bus.i_tx_hold = 1'b1;
        for (int t = 1; t <= 5; t++)
            send(64'h3000_0000 + 64'(t * 'h100), 10'd8, 8'(t), 16'(16'h0100 + t));
        tick();
        check("fifo_full", 64'(bus.o_req_ready), 0);
        set_req(64'h3000_0600, 10'd8, 8'd6, 16'h0106);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("full_blocks", 64'(bus.o_req_ready), 0);
        end
        bus.i_tx_hold = 1'b0;
        finish_push();
        wait_idle();

        // Hold in ISSUE suppresses the command; stray last_data while idle is ignored
        bus.i_tx_hold = 1'b1;
        base = seg_count;
        send(64'h5000_0010, 10'd16, 8'h55, 16'h5555);
        repeat (3) tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_no_rd_en", 64'(seg_count - base), 0);
        end
        bus.i_tx_hold = 1'b0;
        wait_idle();
        check("hold_released_segs", 64'(seg_count - base), 1);
        man_pulse = 1;
        tick();
        tick();
        check("spurious_busy", 64'(bus.o_busy), 0);
        check("spurious_rd_en", 64'(bus.o_rd_en), 0);
        send(64'h5000_0100, 10'd4, 8'h56, 16'h5556);
        wait_idle();

        // Asynchronous reset while a segment is outstanding
        auto_resp = 0;
        base = seg_count;
        send(64'h6000_0000, 10'd80, 8'h66, 16'h6666);
        n = 0;
        while (seg_count == base && n < 50) begin
            tick();
            n++;
        end
        check("t6_first_seg", 64'(seg_count - base), 1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        pending      = 0;
        outstanding  = 0;
        last_ld_tick = -1;
        repeat (2) tick();
        rst_n = 1'b1;
        auto_resp = 1;
        tick();
        base = seg_count;
        send(64'h7000_0004, 10'd40, 8'h77, 16'h7777);
        wait_idle();
        check("t6_new_segs", 64'(seg_count - base), 2);
        check("t6_last_bc", 64'(bus.o_cpl_byte_cnt), 32);
        check("t6_last_addr", bus.o_rd_addr, 64'h7000_0084);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
